// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - aligned store queue between MEM stage and data RAM (optional STORE_FWD_EN: load/store word conflict detect)
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_sel,
  output logic        ram_write_en,
  input  logic        ram_ready,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  output logic [3:0]  ram_write_sel,
  output logic        misalign,
  output logic        empty,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict
);

  localparam int AW = $clog2(DEPTH);

  // Entries hold a word address plus lane-aligned data and byte enables,
  // so the RAM side never has to look at the original store size.
  logic [29:0] entry_addr [DEPTH];
  logic [31:0] entry_data [DEPTH];
  logic [3:0]  entry_sel  [DEPTH];

  // Pointers carry one extra MSB that acts as the wrap bit; with a
  // power-of-two depth a plain increment wraps the index and toggles it.
  logic [AW:0] wr_cnt;
  logic [AW:0] rd_cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic full;
  logic accept;
  logic push;
  logic pop;

  logic        legal;
  logic [3:0]  al_sel;
  logic [31:0] al_data;

  assign wr_idx = wr_cnt[AW-1:0];
  assign rd_idx = rd_cnt[AW-1:0];

  assign empty = (wr_cnt == rd_cnt);
  assign full  = (wr_idx == rd_idx) && (wr_cnt[AW] != rd_cnt[AW]);

  // No bypass when full: a pop this cycle only frees space for next cycle.
  assign st_ready = !full;

  // Illegal stores are still consumed so the pipeline never stalls on them.
  assign accept = st_valid && st_ready;
  assign push   = accept && legal;

  assign ram_write_en = !empty;
  assign pop          = ram_write_en && ram_ready;

  // Lane alignment and legality of the incoming store.
  always_comb begin
    legal   = 1'b0;
    al_sel  = 4'b0000;
    al_data = 32'h0;
    case (st_sel)
      4'b0001: begin
        legal   = 1'b1;
        al_sel  = 4'b0001 << st_addr[1:0];
        al_data = {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000};
      end
      4'b0011: begin
        if (!st_addr[0]) begin
          legal = 1'b1;
          if (st_addr[1]) begin
            al_sel  = 4'b1100;
            al_data = {st_data[15:0], 16'h0};
          end else begin
            al_sel  = 4'b0011;
            al_data = {16'h0, st_data[15:0]};
          end
        end
      end
      4'b1111: begin
        if (st_addr[1:0] == 2'b00) begin
          legal   = 1'b1;
          al_sel  = 4'b1111;
          al_data = st_data;
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Head entry drives the RAM port; outputs are forced to zero while empty.
  always_comb begin
    ram_addr       = 32'h0;
    ram_write_data = 32'h0;
    ram_write_sel  = 4'b0000;
    if (!empty) begin
      ram_addr       = {entry_addr[rd_idx], 2'b00};
      ram_write_data = entry_data[rd_idx];
      ram_write_sel  = entry_sel[rd_idx];
    end
  end

  // Write and read pointer advance; push and pop may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (pop) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Entry storage, written at the tail on an accepted legal store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_addr[i] <= '0;
        entry_data[i] <= '0;
        entry_sel[i]  <= '0;
      end
    end else if (push) begin
      entry_addr[wr_idx] <= st_addr[31:2];
      entry_data[wr_idx] <= al_data;
      entry_sel[wr_idx]  <= al_sel;
    end
  end

  // One-cycle flag for a consumed but rejected store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= accept && !legal;
    end
  end

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0] entry_vld;

  // Per-entry occupancy for the conflict check; a slot is live from push
  // until the cycle after its pop, so the head being popped still matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_vld <= '0;
    end else begin
      if (pop) begin
        entry_vld[rd_idx] <= 1'b0;
      end
      if (push) begin
        entry_vld[wr_idx] <= 1'b1;
      end
    end
  end

  // Word-granular match of the load against every pending store.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_addr[i] == ld_addr[31:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign ld_conflict    = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_sel;
  logic        ram_write_en;
  logic        ram_ready;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [3:0]  ram_write_sel;
  logic        misalign;
  logic        empty;
  logic [31:0] ld_addr;
  logic        ld_conflict;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .st_valid(st_valid),
    .st_ready(st_ready),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_sel(st_sel),
    .ram_write_en(ram_write_en),
    .ram_ready(ram_ready),
    .ram_addr(ram_addr),
    .ram_write_data(ram_write_data),
    .ram_write_sel(ram_write_sel),
    .misalign(misalign),
    .empty(empty),
    .ld_addr(ld_addr),
    .ld_conflict(ld_conflict)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted RAM write is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ram_write_en && ram_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h, expected no write", ram_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("ram_addr", ram_addr, mon_e.a);
        check("ram_write_data", ram_write_data, mon_e.d);
        check("ram_write_sel", {28'h0, ram_write_sel}, {28'h0, mon_e.s});
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_sel   = s;
    t = 0;
    @(negedge clk);
    while (!st_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!st_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got st_ready 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    ram_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || !empty) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0 || !empty) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    ram_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    st_sel    = 4'b0000;
    ram_ready = 1'b0;
    ld_addr   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_write_en", {31'h0, ram_write_en}, 32'h0);
    check("rst_empty", {31'h0, empty}, 32'h1);
    check("rst_st_ready", {31'h0, st_ready}, 32'h1);
    check("rst_ld_conflict", {31'h0, ld_conflict}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Aligned byte, half and word stores with the RAM always ready.
    ram_ready = 1'b1;
    expect_wr(32'h100, 32'hAB000000, 4'b1000);
    send(32'h103, 32'h000000AB, 4'b0001);
    expect_wr(32'h100, 32'h0000FF00, 4'b0010);
    send(32'h101, 32'h000001FF, 4'b0001);
    expect_wr(32'h200, 32'h12340000, 4'b1100);
    send(32'h202, 32'h00001234, 4'b0011);
    expect_wr(32'h200, 32'h00005678, 4'b0011);
    send(32'h200, 32'hABCD5678, 4'b0011);
    expect_wr(32'h400, 32'hDEADBEEF, 4'b1111);
    send(32'h400, 32'hDEADBEEF, 4'b1111);
    drain();

    // Rejected stores: misaligned half, misaligned word, unsupported size.
    send(32'h201, 32'h00001234, 4'b0011);
    @(negedge clk);
    check("misalign_half", {31'h0, misalign}, 32'h1);
    check("misalign_half_empty", {31'h0, empty}, 32'h1);
    @(negedge clk);
    check("misalign_pulse_end", {31'h0, misalign}, 32'h0);
    @(posedge clk);
    #1;
    send(32'h402, 32'h11111111, 4'b1111);
    @(negedge clk);
    check("misalign_word", {31'h0, misalign}, 32'h1);
    @(posedge clk);
    #1;
    send(32'h400, 32'h22222222, 4'b0111);
    @(negedge clk);
    check("misalign_sel", {31'h0, misalign}, 32'h1);
    check("misalign_sel_empty", {31'h0, empty}, 32'h1);
    @(posedge clk);
    #1;

    // Backpressure: fill the queue, then free exactly one slot.
    ram_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_wr(32'h500 + 32'(4 * i), 32'h1000 + 32'(i), 4'b1111);
      send(32'h500 + 32'(4 * i), 32'h1000 + 32'(i), 4'b1111);
    end
    @(negedge clk);
    check("full_st_ready", {31'h0, st_ready}, 32'h0);
    check("full_head_addr_held", ram_addr, 32'h500);
    @(posedge clk);
    #1;
    ram_ready = 1'b1;
    @(posedge clk);
    #1;
    ram_ready = 1'b0;
    @(negedge clk);
    check("after_pop_st_ready", {31'h0, st_ready}, 32'h1);
    @(posedge clk);
    #1;
    drain();

    // Push and pop in the same cycle while holding two entries.
    expect_wr(32'h600, 32'hA0A0A0A0, 4'b1111);
    send(32'h600, 32'hA0A0A0A0, 4'b1111);
    expect_wr(32'h604, 32'hB1B1B1B1, 4'b1111);
    send(32'h604, 32'hB1B1B1B1, 4'b1111);
    ram_ready = 1'b1;
    expect_wr(32'h608, 32'hC2C2C2C2, 4'b1111);
    send(32'h608, 32'hC2C2C2C2, 4'b1111);
    ram_ready = 1'b0;
    @(negedge clk);
    check("pushpop_not_empty", {31'h0, empty}, 32'h0);
    @(posedge clk);
    #1;
    ram_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ram_ready = 1'b0;
    @(negedge clk);
    check("pushpop_count2_empty", {31'h0, empty}, 32'h1);
    check("pushpop_sb_drained", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;

    // Load conflict against a pending word store.
    expect_wr(32'h300, 32'h11223344, 4'b1111);
    send(32'h300, 32'h11223344, 4'b1111);
    ld_addr = 32'h302;
    @(negedge clk);
    check("ld_conflict_match", {31'h0, ld_conflict}, {31'h0, FWD});
    ld_addr = 32'h304;
    #1;
    check("ld_conflict_other_word", {31'h0, ld_conflict}, 32'h0);
    @(posedge clk);
    #1;
    drain();

    // Reset with three stores pending discards them.
    for (int i = 0; i < 3; i++) begin
      send(32'h700 + 32'(4 * i), 32'h7000 + 32'(i), 4'b1111);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ram_write_en", {31'h0, ram_write_en}, 32'h0);
    check("midrst_empty", {31'h0, empty}, 32'h1);
    check("midrst_st_ready", {31'h0, st_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ram_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postrst_no_write", {31'h0, ram_write_en}, 32'h0);
    end
    @(posedge clk);
    #1;
    expect_wr(32'h000, 32'h005A0000, 4'b0100);
    send(32'h002, 32'h0000005A, 4'b0001);
    drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of store-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port st_valid, input, 1 bit: MEM-stage store request valid.
REQ-005 SHALL have port st_ready, output, 1 bit: buffer can accept a store this cycle.
REQ-006 SHALL have port st_addr, input, 32 bits: store byte address.
REQ-007 SHALL have port st_data, input, 32 bits: store data, right-justified.
REQ-008 SHALL have port st_sel, input, 4 bits: store size; 4'b0001 is byte, 4'b0011 is half, 4'b1111 is word.
REQ-009 SHALL have port ram_write_en, output, 1 bit: RAM write request valid.
REQ-010 SHALL have port ram_ready, input, 1 bit: RAM accepts the write this cycle.
REQ-011 SHALL have port ram_addr, output, 32 bits: word-aligned write address, bits [1:0] = 0.
REQ-012 SHALL have port ram_write_data, output, 32 bits: lane-aligned write data.
REQ-013 SHALL have port ram_write_sel, output, 4 bits: per-lane byte enables.
REQ-014 SHALL have port misalign, output, 1 bit: one-cycle pulse for a rejected store.
REQ-015 SHALL have port empty, output, 1 bit: no pending entries.
REQ-016 SHALL have port ld_addr, input, 32 bits: load address to check against pending stores.
REQ-017 SHALL have port ld_conflict, output, 1 bit: load word-address matches a pending store.

Function
REQ-018 SHALL hold stores in a DEPTH-entry circular FIFO with read and write pointers plus a wrap bit; full when the pointers are equal and the wrap bits differ.
REQ-019 SHALL drive st_ready = !full, with no same-cycle bypass when full, even if a pop occurs.
REQ-020 SHALL accept a store on st_valid && st_ready and complete alignment at enqueue.
- Byte: sel = 4'b0001 << addr[1:0]; data = st_data[7:0] shifted by 8*addr[1:0].
- Half: lanes 1:0 when addr[1] = 0, lanes 3:2 when addr[1] = 1.
- Word: all lanes.
- Unselected lanes SHALL be zero.
REQ-021 SHALL NOT enqueue a store that is a half with addr[0] = 1, a word with addr[1:0] != 0, or any other st_sel value; such a store SHALL still be consumed (st_ready unchanged) and misalign SHALL be registered high for exactly the next cycle.
REQ-022 SHALL drive ram_write_en = !empty, with ram_addr, ram_write_data and ram_write_sel taken from the head entry; all four SHALL be held stable until ram_ready.
REQ-023 SHALL pop the head on ram_write_en && ram_ready.
REQ-024 SHALL present a store accepted in cycle N on the RAM port no earlier than cycle N+1.
REQ-025 SHALL complete a simultaneous push and pop in one cycle with occupancy unchanged.
REQ-026 SHALL wrap the pointers modulo DEPTH, toggling the wrap bit.
REQ-027 SHALL drive RAM outputs to 0 while empty.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear the pointers, wrap bits, entries and misalign; ram_write_en = 0, empty = 1, st_ready = 1, ld_conflict = 0.
REQ-029 SHALL discard all pending stores on reset mid-operation, with no partial RAM write issued after rst_n rises.

Configuration
REQ-030 SHALL, with STORE_FWD_EN defined, drive ld_conflict combinationally high when ld_addr[31:2] equals the word address of any valid entry, including the head entry being popped this cycle.
REQ-031 SHALL, with STORE_FWD_EN undefined, tie ld_conflict to 0, ignore ld_addr and contain no comparators.

Verification
REQ-032 SHALL verify byte store: addr 0x103, data 0x000000AB -> ram_addr 0x100, data 0xAB000000, sel 4'b1000.
REQ-033 SHALL verify half stores: addr 0x202, data 0x1234 -> data 0x12340000, sel 4'b1100; addr 0x201 -> misalign pulse, empty stays 1.
REQ-034 SHALL verify backpressure: ram_ready = 0, push DEPTH words -> st_ready = 0; one ram_ready cycle -> st_ready = 1 the next cycle; FIFO order is preserved.
REQ-035 SHALL verify simultaneous push and pop while holding 2 entries -> count stays 2; the wrap-around sequence drains in order.
REQ-036 SHALL verify forwarding: with STORE_FWD_EN, pending word 0x300 and ld_addr 0x302 -> ld_conflict = 1; with the macro undefined -> ld_conflict = 0.
REQ-037 SHALL verify reset mid-operation: rst_n low with 3 entries pending -> ram_write_en = 0 immediately and empty = 1.
